// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and helpers for the ALU logic-unit issue stage.
//   log_op_e     : 3-bit operation code understood by Logic_op
//   FUNCT_*      : MIPS R-type funct encodings of the four logic instructions
//   rsp_err_e    : response status code returned with every result
//   seq_state_e  : sequencer FSM states
//   decode_t     : {legal, op} result of decode_funct
//   decode_funct : pure funct -> {legal, op} decoder
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOR = 3'b011
  } log_op_e;

  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_XOR = 6'h26;
  localparam logic [5:0] FUNCT_NOR = 6'h27;

  // Encoding 2'd3 is reserved and never driven.
  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_TIMEOUT = 2'd2
  } rsp_err_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic    legal;
    log_op_e op;
  } decode_t;

  // Illegal funct values decode to AND so lo_op always carries a defined code.
  function automatic decode_t decode_funct(input logic [5:0] funct);
    decode_t d;
    d.legal = 1'b1;
    d.op    = OP_AND;
    case (funct)
      FUNCT_AND: d.op = OP_AND;
      FUNCT_OR:  d.op = OP_OR;
      FUNCT_XOR: d.op = OP_XOR;
      FUNCT_NOR: d.op = OP_NOR;
      default: begin
        d.legal = 1'b0;
        d.op    = OP_AND;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_logic_sequencer.sv
// -----------------------------------------------------------------------------
// alu_logic_sequencer
// Issue stage in front of the Logic_op unit. Accepts one MIPS R-type logic
// request at a time, decodes funct to log_op, runs the unit's start/finish
// handshake (with a finish timeout) and returns the result or an error code.
//
// Parameters
//   WIDTH   : operand / result width
//   TIMEOUT : WAIT cycles without finish before aborting (2..255)
//   TMR_W   : timeout counter width (derived)
//
// Ports
//   clk, rst_n                         : clock, async active-low reset
//   req_valid/req_ready                : request handshake
//   req_a, req_b, req_funct            : request payload
//   rsp_valid/rsp_ready                : response handshake
//   rsp_c, rsp_err                     : response payload (err 0=OK,1=ILLEGAL,2=TIMEOUT)
//   lo_a, lo_b, lo_op, lo_start        : drive to Logic_op
//   lo_finish, lo_c                    : return from Logic_op
//
// Every output comes straight from a flop. The handshake-flag flops are
// loaded from the next state, so they always equal a decode of the current
// state without any combinational path to the pins.
// -----------------------------------------------------------------------------
module alu_logic_sequencer
  import alu_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int TIMEOUT = 16,
  localparam int TMR_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  // request channel
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [5:0]       req_funct,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_c,
  output logic [1:0]       rsp_err,
  // Logic_op interface
  output logic [WIDTH-1:0] lo_a,
  output logic [WIDTH-1:0] lo_b,
  output logic [2:0]       lo_op,
  output logic             lo_start,
  input  logic             lo_finish,
  input  logic [WIDTH-1:0] lo_c
);

  // Last WAIT timer value; reaching it without finish aborts the operation,
  // so WAIT lasts exactly TIMEOUT cycles.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  seq_state_e       state_r,     state_nxt_s;
  logic [TMR_W-1:0] tmr_r,       tmr_nxt_s;
  logic [WIDTH-1:0] lo_a_r,      lo_a_nxt_s;
  logic [WIDTH-1:0] lo_b_r,      lo_b_nxt_s;
  log_op_e          lo_op_r,     lo_op_nxt_s;
  logic [WIDTH-1:0] rsp_c_r,     rsp_c_nxt_s;
  rsp_err_e         rsp_err_r,   rsp_err_nxt_s;
  logic             lo_start_r;
  logic             req_ready_r;
  logic             rsp_valid_r;
  decode_t          dec_s;
  logic             accept_s;

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_c     = rsp_c_r;
  assign rsp_err   = rsp_err_r;
  assign lo_a      = lo_a_r;
  assign lo_b      = lo_b_r;
  assign lo_op     = lo_op_r;
  assign lo_start  = lo_start_r;

  assign dec_s    = decode_funct(req_funct);
  assign accept_s = req_valid && req_ready_r;

  // Next-state, timer and datapath-register update logic.
  always_comb begin
    state_nxt_s   = state_r;
    tmr_nxt_s     = tmr_r;
    lo_a_nxt_s    = lo_a_r;
    lo_b_nxt_s    = lo_b_r;
    lo_op_nxt_s   = lo_op_r;
    rsp_c_nxt_s   = rsp_c_r;
    rsp_err_nxt_s = rsp_err_r;

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          // Operands are only loaded here, so they stay frozen while busy.
          lo_a_nxt_s  = req_a;
          lo_b_nxt_s  = req_b;
          lo_op_nxt_s = dec_s.op;
          if (dec_s.legal) begin
            state_nxt_s = ISSUE;
          end else begin
            // Illegal funct answers directly and never starts the unit.
            state_nxt_s   = RESP;
            rsp_c_nxt_s   = '0;
            rsp_err_nxt_s = ERR_ILLEGAL;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end

      ISSUE: begin
        tmr_nxt_s = '0;
        if (lo_finish) begin
          // Combinational unit: result is already valid in the start cycle.
          state_nxt_s   = RESP;
          rsp_c_nxt_s   = lo_c;
          rsp_err_nxt_s = ERR_OK;
        end else begin
          state_nxt_s = WAIT;
        end
      end

      WAIT: begin
        // Finish is tested first so it wins over a simultaneous timeout.
        if (lo_finish) begin
          state_nxt_s   = RESP;
          rsp_c_nxt_s   = lo_c;
          rsp_err_nxt_s = ERR_OK;
        end else if (tmr_r == TMR_LAST) begin
          state_nxt_s   = RESP;
          rsp_c_nxt_s   = '0;
          rsp_err_nxt_s = ERR_TIMEOUT;
        end else begin
          tmr_nxt_s = tmr_r + TMR_ONE;
        end
      end

      RESP: begin
        // A finish arriving here (e.g. after a timeout) is deliberately ignored.
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end

      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, timer, datapath and handshake-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      tmr_r       <= '0;
      lo_a_r      <= '0;
      lo_b_r      <= '0;
      lo_op_r     <= OP_AND;
      rsp_c_r     <= '0;
      rsp_err_r   <= ERR_OK;
      lo_start_r  <= 1'b0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      tmr_r       <= tmr_nxt_s;
      lo_a_r      <= lo_a_nxt_s;
      lo_b_r      <= lo_b_nxt_s;
      lo_op_r     <= lo_op_nxt_s;
      rsp_c_r     <= rsp_c_nxt_s;
      rsp_err_r   <= rsp_err_nxt_s;
      lo_start_r  <= (state_nxt_s == ISSUE);
      req_ready_r <= (state_nxt_s == IDLE);
      rsp_valid_r <= (state_nxt_s == RESP);
    end
  end

endmodule

// File: tb/tb_alu_logic_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_logic_sequencer
// Directed bench: alu_logic_sequencer driving a behavioural Logic_op that can
// act as a combinational unit, a slow unit (finish 5 cycles after start) or a
// unit that never finishes.
// -----------------------------------------------------------------------------
module tb_alu_logic_sequencer;
  import alu_pkg::*;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 16;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [WIDTH-1:0] req_a     = '0;
  logic [WIDTH-1:0] req_b     = '0;
  logic [5:0]       req_funct = 6'h00;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_c;
  logic [1:0]       rsp_err;
  logic [WIDTH-1:0] lo_a;
  logic [WIDTH-1:0] lo_b;
  logic [2:0]       lo_op;
  logic             lo_start;
  logic             lo_finish;
  logic [WIDTH-1:0] lo_c;

  alu_logic_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_funct (req_funct),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_c     (rsp_c),
    .rsp_err   (rsp_err),
    .lo_a      (lo_a),
    .lo_b      (lo_b),
    .lo_op     (lo_op),
    .lo_start  (lo_start),
    .lo_finish (lo_finish),
    .lo_c      (lo_c)
  );

  always #5 clk = ~clk;

  // Logic_op model: 0 = combinational, 1 = slow (finish 5 cycles after start),
  // 2 = never finishes. force_fin injects a stray finish pulse.
  int   model_mode = 0;
  logic force_fin  = 1'b0;
  int   slow_cnt   = 0;

  always @(posedge clk) begin
    if (lo_start) slow_cnt <= 5;
    else if (slow_cnt != 0) slow_cnt <= slow_cnt - 1;
  end

  assign lo_finish = ((model_mode == 0) && lo_start) ||
                     ((model_mode == 1) && (slow_cnt == 1)) || force_fin;

  always_comb begin
    case (lo_op)
      3'b000:  lo_c = lo_a & lo_b;
      3'b001:  lo_c = lo_a | lo_b;
      3'b010:  lo_c = lo_a ^ lo_b;
      3'b011:  lo_c = ~(lo_a | lo_b);
      default: lo_c = '0;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Results of the last issue() call.
  int         lat;
  int         starts;
  logic       rdy_seen;
  logic       ops_moved;
  logic [31:0] snap_a, snap_b;
  logic [2:0]  snap_op;

  // Present one request, then follow the DUT until rsp_valid (bounded).
  // lat counts edges from the accept edge (=1) to the one raising rsp_valid.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] funct, input int limit);
    req_a     = a;
    req_b     = b;
    req_funct = funct;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat       = 1;
    starts    = int'(lo_start);
    rdy_seen  = req_ready;
    snap_a    = lo_a;
    snap_b    = lo_b;
    snap_op   = lo_op;
    ops_moved = 1'b0;
    while (!rsp_valid && lat < limit) begin
      tick();
      lat++;
      starts   += int'(lo_start);
      rdy_seen |= req_ready;
      if (lo_a !== snap_a || lo_b !== snap_b || lo_op !== snap_op) ops_moved = 1'b1;
    end
  endtask

  // Check the pending response, accept it and check the return to IDLE.
  task automatic finish_rsp(input string tag, input logic [31:0] exp_c, input logic [1:0] exp_err);
    check_eq({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check_eq({tag, "_c"},     rsp_c,          exp_c);
    check_eq({tag, "_err"},   32'(rsp_err),   32'(exp_err));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq({tag, "_drop"},  32'(rsp_valid), 32'd0);
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  logic held;

  initial begin
    // ---------------- reset values ----------------
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_lo_start",  32'(lo_start),  32'd0);
    check_eq("rst_lo_a",      lo_a,           32'd0);
    check_eq("rst_lo_op",     32'(lo_op),     32'd0);
    check_eq("rst_rsp_err",   32'(rsp_err),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---------------- AND, combinational unit ----------------
    model_mode = 0;
    issue(32'hF0F0_1234, 32'h0FF0_FFFF, 6'h24, 10);
    check_eq("and_lat",    32'(lat),    32'd2);
    check_eq("and_starts", 32'(starts), 32'd1);
    check_eq("and_op",     32'(snap_op), 32'd0);
    check_eq("and_lo_a",   snap_a,      32'hF0F0_1234);
    finish_rsp("and", 32'h00F0_1234, 2'd0);

    // ---------------- NOR, slow unit ----------------
    model_mode = 1;
    issue(32'h0000_0000, 32'h0000_00FF, 6'h27, 20);
    check_eq("nor_lat",    32'(lat),       32'd7);
    check_eq("nor_starts", 32'(starts),    32'd1);
    check_eq("nor_busy",   32'(rdy_seen),  32'd0);
    check_eq("nor_stable", 32'(ops_moved), 32'd0);
    check_eq("nor_op",     32'(snap_op),   32'd3);
    finish_rsp("nor", 32'hFFFF_FF00, 2'd0);

    // ---------------- illegal funct ----------------
    model_mode = 0;
    issue(32'h1, 32'h2, 6'h20, 10);
    check_eq("ill_lat",    32'(lat),    32'd1);
    check_eq("ill_starts", 32'(starts), 32'd0);
    check_eq("ill_lo_a",   lo_a,        32'h1);
    finish_rsp("ill", 32'h0, 2'd1);

    // ---------------- timeout, then late finish ----------------
    model_mode = 2;
    issue(32'h1234, 32'h5678, 6'h26, 40);
    check_eq("tmo_lat",    32'(lat),      32'd18);
    check_eq("tmo_starts", 32'(starts),   32'd1);
    check_eq("tmo_busy",   32'(rdy_seen), 32'd0);
    force_fin = 1'b1;
    tick();
    force_fin = 1'b0;
    check_eq("tmo_late_c",   rsp_c,         32'h0);
    check_eq("tmo_late_err", 32'(rsp_err),  32'd2);
    finish_rsp("tmo", 32'h0, 2'd2);
    force_fin = 1'b1;
    tick();
    force_fin = 1'b0;
    tick();
    check_eq("tmo_no_2nd_rsp", 32'(rsp_valid), 32'd0);
    check_eq("tmo_idle_ready", 32'(req_ready), 32'd1);
    check_eq("tmo_idle_start", 32'(lo_start),  32'd0);

    // ---------------- backpressure ----------------
    model_mode = 0;
    issue(32'h1, 32'h2, 6'h25, 10);
    check_eq("bp_lat", 32'(lat), 32'd2);
    req_a     = 32'hFFFF_0000;
    req_b     = 32'h1234_5678;
    req_funct = 6'h24;
    req_valid = 1'b1;
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      held &= rsp_valid && (rsp_c == 32'h3) && (rsp_err == 2'd0) && !req_ready && (lo_a == 32'h1);
    end
    check_eq("bp_held", 32'(held), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("bp_drop",  32'(rsp_valid), 32'd0);
    check_eq("bp_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check_eq("bp_next_start", 32'(lo_start), 32'd1);
    check_eq("bp_next_a",     lo_a,          32'hFFFF_0000);
    tick();
    finish_rsp("bp_next", 32'h1234_0000, 2'd0);

    // ---------------- reset while in WAIT ----------------
    model_mode = 1;
    req_a     = 32'hFFFF_FFFF;
    req_b     = 32'h1;
    req_funct = 6'h24;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check_eq("mid_busy", 32'(req_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_ready", 32'(req_ready), 32'd1);
    check_eq("mrst_valid", 32'(rsp_valid), 32'd0);
    check_eq("mrst_lo_a",  lo_a,           32'd0);
    check_eq("mrst_lo_b",  lo_b,           32'd0);
    check_eq("mrst_start", 32'(lo_start),  32'd0);
    check_eq("mrst_c",     rsp_c,          32'd0);
    held = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      held |= rsp_valid;
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_mode = 0;
    tick();
    held |= rsp_valid;
    check_eq("mrst_no_rsp", 32'(held), 32'd0);
    issue(32'hAAAA_AAAA, 32'hFFFF_FFFF, 6'h26, 10);
    check_eq("xor_lat", 32'(lat), 32'd2);
    finish_rsp("xor", 32'h5555_5555, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_logic_sequencer.md
Name: alu_logic_sequencer

Overview:
- Upstream issue stage for the ALU logic unit (Logic_op).
- Accepts MIPS R-type logic requests (operands plus funct) over a valid/ready handshake and decodes funct to the 3-bit log_op.
- Drives the unit's start/finish handshake and captures C.
- Returns the result, or an error code, over a valid/ready response channel.

Parameters:
- WIDTH, 32: operand/result width.
- TIMEOUT, 16: WAIT cycles without finish before aborting; legal range 2..255.
- TMR_W, $clog2(TIMEOUT+1): timeout counter width (derived; do not override).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_funct  in  6  MIPS funct field.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_c  out  WIDTH  result.
- rsp_err  out  2  0=OK, 1=ILLEGAL funct, 2=TIMEOUT.
- lo_a  out  WIDTH  to Logic_op A.
- lo_b  out  WIDTH  to Logic_op B.
- lo_op  out  3  to Logic_op log_op.
- lo_start  out  1  to Logic_op start.
- lo_finish  in  1  from Logic_op finish.
- lo_c  in  WIDTH  from Logic_op C.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - lo_a/lo_b/lo_op/lo_start/rsp_c/rsp_err/rsp_valid all 0.
  - req_ready=1, because it is Moore: req_ready = (state==IDLE).
- Decode: funct 0x24→AND(000), 0x25→OR(001), 0x26→XOR(010), 0x27→NOR(011). Every other funct is ILLEGAL.
- IDLE, on req_valid && req_ready:
  - Register req_a/req_b into lo_a/lo_b and the decoded op into lo_op.
  - Legal funct → ISSUE.
  - Illegal funct → RESP with rsp_c=0, rsp_err=1. lo_start is never asserted.
- ISSUE:
  - lo_start=1 for exactly this one cycle; timer cleared.
  - If lo_finish=1 in this cycle (combinational unit): capture lo_c → RESP, err=0.
  - Otherwise → WAIT.
- WAIT:
  - lo_start=0.
  - lo_finish=1 → rsp_c<=lo_c, err=0 → RESP.
  - Otherwise timer++. When the timer reaches TIMEOUT-1 without finish → RESP, rsp_c=0, err=2.
  - If finish and timeout occur in the same cycle, finish wins.
- RESP:
  - rsp_valid=1; rsp_c/rsp_err held stable until accepted.
  - On rsp_ready → IDLE; rsp_valid drops the next cycle.
  - Backpressure may last indefinitely.
- lo_a/lo_b/lo_op hold stable from ISSUE until the next request acceptance, and are never changed while busy.
- Latency: the minimum for a legal request is accept→rsp_valid = 2 cycles (finish in ISSUE). Throughput is at most one request per 3 cycles; no pipelining.
- lo_finish outside ISSUE/WAIT is ignored, including a late finish after a timeout.
- Reset mid-operation (any state) returns to the reset values immediately. No response is produced for the in-flight request.
- rsp_err=3 is never produced.

Decomposition:
- Package alu_pkg holds:
  - log_op_e enum (AND/OR/XOR/NOR).
  - funct constants FUNCT_AND..FUNCT_NOR.
  - rsp_err_e (OK/ILLEGAL/TIMEOUT).
  - seq_state_e (IDLE/ISSUE/WAIT/RESP).
  - Pure function decode_funct returning {legal, op}.
- No sub-module is needed; the FSM, timer and registers sit in one module.
- Bench top instantiates alu_logic_sequencer feeding Logic_op.

Test Plan:
- Legal AND, combinational unit: A=0xF0F0_1234, B=0x0FF0_FFFF, funct=0x24 → lo_start pulse of exactly 1 cycle, lo_op=000, rsp_c=0x00F0_1234, err=0, rsp_valid 2 cycles after accept.
- Legal NOR via slow-model Logic_op (finish 5 cycles after start): A=0, B=0x0000_00FF → rsp_c=0xFFFF_FF00, err=0; req_ready low throughout; lo_a/lo_b stable through WAIT.
- Illegal funct=0x20: A=1, B=2 → no lo_start, rsp_c=0, err=1, rsp_valid 1 cycle after accept.
- Timeout with TIMEOUT=16 and a finish-never model → rsp_valid after ISSUE plus 16 WAIT cycles, err=2, rsp_c=0. A late finish then produces no second response.
- Backpressure: hold rsp_ready=0 for 10 cycles with OR, A=0x1, B=0x2 → rsp_c=0x3 held stable, req_ready=0 until the handshake, next request accepted in the IDLE cycle after.
- Reset in WAIT: deassert rst_n mid-operation → all outputs at reset values asynchronously, no rsp_valid. A subsequent XOR with A=0xAAAA_AAAA, B=0xFFFF_FFFF → rsp_c=0x5555_5555.
